// File: rtl/timing_generator_param_if.sv
// Clock-enable bundle from the timing generator to the core blocks.
// The generator uses the master modport; consumers of the enables use the slave modport.
interface timing_generator_param_if #(
    parameter int N_CH = 4
);
    logic            SLOW_REQ;
    logic            PIX_en;
    logic [N_CH-1:0] EN_VEC;
    logic            PROC_en;
    logic            hPROC_en;
    logic            SLOW_ACK;
    logic            TTX_en;
    logic            V_TURN;

    modport master (
        input  SLOW_REQ,
        output PIX_en, EN_VEC, PROC_en, hPROC_en, SLOW_ACK, TTX_en, V_TURN
    );

    modport slave (
        output SLOW_REQ,
        input  PIX_en, EN_VEC, PROC_en, hPROC_en, SLOW_ACK, TTX_en, V_TURN
    );
endinterface

// File: rtl/timing_generator_param.sv
// Single-clock timing generator: every system enable is decoded from one master counter.
// Define TG_STRETCH_EN to enable 1MHz-bus stretching of the processor enable (SLOW_REQ/SLOW_ACK).
module timing_generator_param #(
    parameter int          PIX_DIV  = 2,
    parameter int          MASTER_W = 5,
    parameter int          N_CH     = 4,
    parameter int          PROC_TAP = 2,
    parameter int          PROC_PH  = 3,
    parameter logic [15:0] TTX_MASK = 16'h2AA8
) (
    input  logic                     CLK100MHZ,
    input  logic                     nRESET,
    timing_generator_param_if.master tg
);
    localparam int PIX_W   = $clog2(PIX_DIV);
    localparam int TTX_CLR = 3;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_STRETCH = 1'b1
    } state_t;

    logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [MASTER_W-1:0] master_q, master_d;
    logic [3:0]          ttx_cnt_q, ttx_cnt_d;
    logic [PROC_PH-1:0]  ring_q, ring_d;
    state_t              state_q, state_d;
    logic                v_turn_q, v_turn_d;

    logic                pix_en_s;
    logic [N_CH-1:0]     en_vec_s;
    logic                tap_s;
    logic                tap_hi_s;
    logic                top_s;
    logic                proc_en_s;
    logic                slow_ack_s;

    function automatic logic [PROC_PH-1:0] rotl(input logic [PROC_PH-1:0] r);
        return {r[PROC_PH-2:0], r[PROC_PH-1]};
    endfunction

    // Enable ladder: each EN_VEC bit requires all lower master bits set, so higher bits nest in lower ones.
    always_comb begin
        logic chain;
        pix_en_s = (pix_cnt_q == PIX_W'(PIX_DIV - 1));
        chain    = pix_en_s;
        en_vec_s = '0;
        for (int k = 0; k < N_CH; k++) begin
            chain       = chain & master_q[k];
            en_vec_s[k] = chain;
        end
        tap_s    = en_vec_s[PROC_TAP];
        tap_hi_s = en_vec_s[PROC_TAP+1];
        top_s    = ring_q[PROC_PH-1];
    end

    // Free-running counters and the video/CPU turn flag.
    always_comb begin
        if (pix_en_s) begin
            pix_cnt_d = '0;
            master_d  = master_q + MASTER_W'(1);
        end else begin
            pix_cnt_d = pix_cnt_q + PIX_W'(1);
            master_d  = master_q;
        end
        if (en_vec_s[TTX_CLR]) begin
            ttx_cnt_d = 4'd0;
        end else if (pix_en_s) begin
            ttx_cnt_d = ttx_cnt_q + 4'd1;
        end else begin
            ttx_cnt_d = ttx_cnt_q;
        end
        if (en_vec_s[PROC_TAP-1]) begin
            v_turn_d = en_vec_s[PROC_TAP];
        end else begin
            v_turn_d = v_turn_q;
        end
    end

    // Processor phase ring and stretch FSM.
    always_comb begin
        state_d    = state_q;
        ring_d     = ring_q;
        proc_en_s  = 1'b0;
        slow_ack_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                proc_en_s = top_s & tap_s;
                if (tap_s) begin
                    ring_d = rotl(ring_q);
                end else begin
                    ring_d = ring_q;
                end
`ifdef TG_STRETCH_EN
                if (proc_en_s && tg.SLOW_REQ) begin
                    state_d = ST_STRETCH;
                end else begin
                    state_d = ST_RUN;
                end
`else
                state_d = ST_RUN;
`endif
            end
            ST_STRETCH: begin
`ifdef TG_STRETCH_EN
                // The pending pulse waits for the next coarser tap; the ring freezes while it waits.
                proc_en_s = top_s & tap_hi_s;
                if (proc_en_s) begin
                    slow_ack_s = 1'b1;
                    ring_d     = rotl(ring_q);
                    state_d    = ST_RUN;
                end else if (tap_s && !top_s) begin
                    ring_d = rotl(ring_q);
                end else begin
                    ring_d = ring_q;
                end
`else
                state_d = ST_RUN;
`endif
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK100MHZ) begin
        if (!nRESET) begin
            pix_cnt_q <= '0;
            master_q  <= '0;
            ttx_cnt_q <= 4'd0;
            ring_q    <= PROC_PH'(1);
            state_q   <= ST_RUN;
            v_turn_q  <= 1'b0;
        end else begin
            pix_cnt_q <= pix_cnt_d;
            master_q  <= master_d;
            ttx_cnt_q <= ttx_cnt_d;
            ring_q    <= ring_d;
            state_q   <= state_d;
            v_turn_q  <= v_turn_d;
        end
    end

    assign tg.PIX_en   = pix_en_s;
    assign tg.EN_VEC   = en_vec_s;
    assign tg.PROC_en  = proc_en_s;
    assign tg.hPROC_en = proc_en_s & tap_hi_s;
    assign tg.SLOW_ACK = slow_ack_s;
    assign tg.TTX_en   = pix_en_s & TTX_MASK[ttx_cnt_q];
    assign tg.V_TURN   = v_turn_q;
endmodule

// File: tb/tb_timing_generator_param.sv
// Directed bench for timing_generator_param: expected enables come from hand-derived cycle
// numbers and closed-form period formulas; stretch scenarios depend on TG_STRETCH_EN.
module tb_timing_generator_param;
    logic CLK100MHZ = 1'b0;
    logic nRESET    = 1'b0;

    timing_generator_param_if tg_if ();

    timing_generator_param dut (
        .CLK100MHZ (CLK100MHZ),
        .nRESET    (nRESET),
        .tg        (tg_if.master)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    int          cyc;
    int          err_cnt;
    int          chk_cnt;
    logic [15:0] ttx_mask_r;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit hit4(input int c, input int a0, input int a1, input int a2, input int a3);
        return (c == a0) || (c == a1) || (c == a2) || (c == a3);
    endfunction

    task automatic tick();
        @(posedge CLK100MHZ);
        #1;
        cyc++;
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_pix"},   32'(tg_if.PIX_en),   32'd0);
        check_val({tag, "_envec"}, 32'(tg_if.EN_VEC),   32'd0);
        check_val({tag, "_proc"},  32'(tg_if.PROC_en),  32'd0);
        check_val({tag, "_hproc"}, 32'(tg_if.hPROC_en), 32'd0);
        check_val({tag, "_ack"},   32'(tg_if.SLOW_ACK), 32'd0);
        check_val({tag, "_ttx"},   32'(tg_if.TTX_en),   32'd0);
        check_val({tag, "_vturn"}, 32'(tg_if.V_TURN),   32'd0);
    endtask

    // Per-cycle check: p* = PROC_en cycles, h* = hPROC_en cycles, k0 = SLOW_ACK cycle (-1 unused).
    task automatic check_cycle(input int p0, input int p1, input int p2, input int p3,
                               input int h0, input int h1, input int k0);
        int       m;
        logic     pix;
        logic [3:0] en_exp;
        logic     v_exp;
        pix = (cyc % 2) == 1;
        m   = ((cyc - 1) / 2) % 32;
        for (int k = 0; k < 4; k++) begin
            en_exp[k] = pix && (((m + 1) % (1 << (k + 1))) == 0);
        end
        v_exp = (cyc >= 16) && (((cyc - 16) % 16) < 8);
        check_val("pix_en",   32'(tg_if.PIX_en),   32'(pix));
        check_val("en_vec",   32'(tg_if.EN_VEC),   32'(en_exp));
        check_val("proc_en",  32'(tg_if.PROC_en),  32'(hit4(cyc, p0, p1, p2, p3)));
        check_val("hproc_en", 32'(tg_if.hPROC_en), 32'(hit4(cyc, h0, h1, -1, -1)));
        check_val("slow_ack", 32'(tg_if.SLOW_ACK), 32'(cyc == k0));
        check_val("ttx_en",   32'(tg_if.TTX_en),   32'(pix && ttx_mask_r[m % 16]));
        check_val("v_turn",   32'(tg_if.V_TURN),   32'(v_exp));
    endtask

    task automatic run_seq(input int last, input int slow_at,
                           input int p0, input int p1, input int p2, input int p3,
                           input int h0, input int h1, input int k0);
        for (int i = 0; i < last; i++) begin
            tick();
            tg_if.SLOW_REQ = (cyc == slow_at);
            check_cycle(p0, p1, p2, p3, h0, h1, k0);
        end
        tg_if.SLOW_REQ = 1'b0;
    endtask

    task automatic do_reset();
        nRESET         = 1'b0;
        tg_if.SLOW_REQ = 1'b0;
        repeat (3) tick();
        check_zero("rst");
        nRESET = 1'b1;
        cyc    = 0;
    endtask

    initial begin
        err_cnt        = 0;
        chk_cnt        = 0;
        cyc            = 0;
        ttx_mask_r     = 16'h2AA8;
        tg_if.SLOW_REQ = 1'b0;

`ifdef TG_STRETCH_EN
        // Free run, then stretch from 95 (held at 143, released at 159), then no-delay stretch from 47.
        do_reset();
        run_seq(200, -1, 47, 95, 143, 191, 95, 191, -1);
        do_reset();
        run_seq(216, 95, 47, 95, 159, 207, 95, 159, 159);
        do_reset();
        run_seq(200, 47, 47, 95, 143, 191, 95, 191, 95);
        // Reset while stretching: outputs clear, no SLOW_ACK, clean restart.
        do_reset();
        run_seq(150, 95, 47, 95, -1, -1, 95, -1, -1);
`else
        // SLOW_REQ has no effect: PROC_en stays periodic and SLOW_ACK stays low.
        do_reset();
        run_seq(200, 95, 47, 95, 143, 191, 95, 191, -1);
        do_reset();
        run_seq(150, 95, 47, 95, 143, -1, 95, -1, -1);
`endif
        nRESET = 1'b0;
        tick();
        check_zero("midrst");
        tick();
        check_zero("midrst_hold");
        nRESET = 1'b1;
        cyc    = 0;
        run_seq(64, -1, 47, -1, -1, -1, -1, -1, -1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
